// File: rtl/object_track_pkg.sv
`default_nettype none
// ============================================================================
// Module      : object_track_pkg
// Description : Shared types and display constants for the object tracking
//               path (locator and overlay stages).
// Revision    : 1.0 - initial release
// ============================================================================
package object_track_pkg;

  // Default display geometry, shared with the overlay stage
  localparam int DEF_DISP_WIDTH = 11;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;

  // Locator frame-tracking states
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

endpackage : object_track_pkg
`default_nettype wire

// File: rtl/bbox_axis.sv
`default_nettype none
// ============================================================================
// Module      : bbox_axis
// Description : Running min/max tracker for one coordinate axis. The *_upd
//               outputs include the current sample so a frame can be closed
//               on the same cycle its last pixel arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module bbox_axis
  import object_track_pkg::*;
#(
  parameter int W = DEF_DISP_WIDTH
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         clear,
  input  logic         sample,
  input  logic [W-1:0] coord,
  output logic [W-1:0] min,
  output logic [W-1:0] max,
  output logic [W-1:0] min_upd,
  output logic [W-1:0] max_upd
);

  logic [W-1:0] min_q, min_d;
  logic [W-1:0] max_q, max_d;

  // Merge the current sample, then let a clear restart the extremes
  always_comb begin
    min_upd = min_q;
    max_upd = max_q;
    if (sample && (coord < min_q)) min_upd = coord;
    if (sample && (coord > max_q)) max_upd = coord;
    min_d = clear ? {W{1'b1}} : min_upd;
    max_d = clear ? {W{1'b0}} : max_upd;
  end

  // Extremes registers; min idles at all-ones, max at zero
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      min_q <= {W{1'b1}};
      max_q <= {W{1'b0}};
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min = min_q;
  assign max = max_q;

endmodule : bbox_axis
`default_nettype wire

// File: rtl/object_locate.sv
`default_nettype none
// ============================================================================
// Module      : object_locate
// Description : Per-frame bounding-box locator. Tracks mask hits over a frame,
//               snapshots the box at the last active pixel and publishes its
//               centre one cycle later with a single-cycle obj_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module object_locate
  import object_track_pkg::*;
#(
  parameter int DISP_WIDTH  = DEF_DISP_WIDTH,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int MIN_PIXELS  = 16,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic                  is_obj,
  input  logic [DISP_WIDTH-1:0] x_pos,
  input  logic [DISP_WIDTH-1:0] y_pos,
  output logic [DISP_WIDTH-1:0] x_obj,
  output logic [DISP_WIDTH-1:0] y_obj,
  output logic                  found,
  output logic                  obj_valid
);

  localparam logic [DISP_WIDTH-1:0]  X_LAST   = DISP_WIDTH'(H_ACTIVE - 1);
  localparam logic [DISP_WIDTH-1:0]  Y_LAST   = DISP_WIDTH'(V_ACTIVE - 1);
  localparam logic [COUNT_WIDTH-1:0] HITS_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] MIN_HITS = COUNT_WIDTH'(MIN_PIXELS);

  // Pixel qualification
  logic w_accept, w_hit, w_eof;
  assign w_accept = enable && (x_pos <= X_LAST) && (y_pos <= Y_LAST);
  assign w_hit    = w_accept && is_obj;
  assign w_eof    = w_accept && (x_pos == X_LAST) && (y_pos == Y_LAST);

  // Per-axis extremes; the end-of-frame pixel is merged via *_upd
  logic [DISP_WIDTH-1:0] x_min, x_max, x_min_upd, x_max_upd;
  logic [DISP_WIDTH-1:0] y_min, y_max, y_min_upd, y_max_upd;

  bbox_axis #(.W(DISP_WIDTH)) u_axis_x (
    .clk     (clk),
    .areset  (areset),
    .clear   (w_eof),
    .sample  (w_hit),
    .coord   (x_pos),
    .min     (x_min),
    .max     (x_max),
    .min_upd (x_min_upd),
    .max_upd (x_max_upd)
  );

  bbox_axis #(.W(DISP_WIDTH)) u_axis_y (
    .clk     (clk),
    .areset  (areset),
    .clear   (w_eof),
    .sample  (w_hit),
    .coord   (y_pos),
    .min     (y_min),
    .max     (y_max),
    .min_upd (y_min_upd),
    .max_upd (y_max_upd)
  );

  // Saturating hit counter
  logic [COUNT_WIDTH-1:0] hits_q, hits_d, hits_upd;

  // Count this pixel's hit, then restart on end of frame
  always_comb begin
    hits_upd = hits_q;
    if (w_hit && (hits_q != HITS_MAX)) hits_upd = hits_q + 1'b1;
    hits_d = w_eof ? '0 : hits_upd;
  end

  // Hit counter register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) hits_q <= '0;
    else        hits_q <= hits_d;
  end

  // Snapshot of the closed frame, including its final pixel
  logic [DISP_WIDTH-1:0]  snap_xmin_q, snap_xmax_q, snap_ymin_q, snap_ymax_q;
  logic [COUNT_WIDTH-1:0] snap_hits_q;

  // Capture accumulators at end of frame; held until the next one
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      snap_xmin_q <= {DISP_WIDTH{1'b1}};
      snap_xmax_q <= '0;
      snap_ymin_q <= {DISP_WIDTH{1'b1}};
      snap_ymax_q <= '0;
      snap_hits_q <= '0;
    end else if (w_eof) begin
      snap_xmin_q <= x_min_upd;
      snap_xmax_q <= x_max_upd;
      snap_ymin_q <= y_min_upd;
      snap_ymax_q <= y_max_upd;
      snap_hits_q <= hits_upd;
    end
  end

  // Centre arithmetic with one guard bit so the sum cannot wrap
  logic [DISP_WIDTH:0]   x_sum, y_sum;
  logic [DISP_WIDTH-1:0] x_ctr, y_ctr;
  logic                  snap_ok;
  assign x_sum   = {1'b0, snap_xmin_q} + {1'b0, snap_xmax_q};
  assign y_sum   = {1'b0, snap_ymin_q} + {1'b0, snap_ymax_q};
  assign x_ctr   = DISP_WIDTH'(x_sum >> 1);
  assign y_ctr   = DISP_WIDTH'(y_sum >> 1);
  // A frame with no hits is never a detection, even if MIN_PIXELS is 0
  assign snap_ok = (snap_hits_q >= MIN_HITS) && (snap_hits_q != '0);

  // FSM and output registers
  state_e                state_q, state_d;
  logic [DISP_WIDTH-1:0] x_obj_q, x_obj_d, y_obj_q, y_obj_d;
  logic                  found_q, found_d, valid_q, valid_d;

  // State and output registers
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_SEARCH;
      x_obj_q <= '0;
      y_obj_q <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_obj_q <= x_obj_d;
      y_obj_q <= y_obj_d;
      found_q <= found_d;
      valid_q <= valid_d;
    end
  end

  // Next state and output refresh; outputs only move in UPDATE
  always_comb begin
    state_d = state_q;
    x_obj_d = x_obj_q;
    y_obj_d = y_obj_q;
    found_d = found_q;
    valid_d = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (w_eof)      state_d = ST_UPDATE;
        else if (w_hit) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (w_eof) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        valid_d = 1'b1;
        if (snap_ok) begin
          x_obj_d = x_ctr;
          y_obj_d = y_ctr;
          found_d = 1'b1;
        end else begin
          found_d = 1'b0;
        end
        // The pixel arriving now belongs to the new frame
        if (w_eof)      state_d = ST_UPDATE;
        else if (w_hit) state_d = ST_TRACK;
        else            state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  assign x_obj     = x_obj_q;
  assign y_obj     = y_obj_q;
  assign found     = found_q;
  assign obj_valid = valid_q;

endmodule : object_locate
`default_nettype wire

// File: tb/tb_object_locate.sv
`default_nettype none
// ============================================================================
// Module      : tb_object_locate
// Description : Self-checking bench for object_locate. Two instances share
//               one pixel stream: default MIN_PIXELS (16) and MIN_PIXELS = 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_object_locate;
  import object_track_pkg::*;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b0;
  logic        is_obj = 1'b0;
  logic [10:0] x_pos = '0;
  logic [10:0] y_pos = '0;
  logic [10:0] x_obj0, y_obj0, x_obj1, y_obj1;
  logic        found0, found1, valid0, valid1;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct packed {
    logic        d;
    logic [31:0] cyc;
    logic [10:0] x;
    logic [10:0] y;
    logic        f;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];

  always #5 clk = ~clk;

  object_locate dut0 (
    .clk(clk), .areset(areset), .enable(enable), .is_obj(is_obj),
    .x_pos(x_pos), .y_pos(y_pos),
    .x_obj(x_obj0), .y_obj(y_obj0), .found(found0), .obj_valid(valid0)
  );

  object_locate #(.MIN_PIXELS(1)) dut1 (
    .clk(clk), .areset(areset), .enable(enable), .is_obj(is_obj),
    .x_pos(x_pos), .y_pos(y_pos),
    .x_obj(x_obj1), .y_obj(y_obj1), .found(found1), .obj_valid(valid1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every obj_valid pulse with the cycle it appeared in
  always @(negedge clk) begin
    if (valid0 === 1'b1) obs_q.push_back('{1'b0, 32'(cyc), x_obj0, y_obj0, found0});
    if (valid1 === 1'b1) obs_q.push_back('{1'b1, 32'(cyc), x_obj1, y_obj1, found1});
  end

  // One pixel for one cycle; inputs change 1 ns after the rising edge
  task automatic px(input logic en, input logic obj, input int x, input int y);
    enable = en;
    is_obj = obj;
    x_pos  = 11'(x);
    y_pos  = 11'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(1'b0, 1'b0, 0, 0);
  endtask

  // Expected results for both instances, due 2 cycles after the EOF pixel
  task automatic expect_frame(input int x0, input int y0, input logic f0,
                              input int x1, input int y1, input logic f1);
    exp_q.push_back('{1'b0, 32'(cyc + 2), 11'(x0), 11'(y0), f0});
    exp_q.push_back('{1'b1, 32'(cyc + 2), 11'(x1), 11'(y1), f1});
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({x_obj0, y_obj0, found0, valid0} !== 24'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs dut0: got x=%0d y=%0d found=%0d valid=%0d, required all 0",
               x_obj0, y_obj0, found0, valid0);
    end
    tests_run++;
    if ({x_obj1, y_obj1, found1, valid1} !== 24'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs dut1: got x=%0d y=%0d found=%0d valid=%0d, required all 0",
               x_obj1, y_obj1, found1, valid1);
    end
    areset = 1'b0;
    idle(3);
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_no_pulse: got %0d obj_valid pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_square;
    res_t e, o;
    for (int y = 20; y <= 23; y++)
      for (int x = 10; x <= 13; x++) px(1'b1, 1'b1, x, y);
    expect_frame(11, 21, 1'b1, 11, 21, 1'b1);
    px(1'b1, 1'b0, 639, 479);
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL square dut%0d: got no obj_valid, required cyc=%0d x=%0d y=%0d found=%0d", e.d, e.cyc, e.x, e.y, e.f);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL square dut%0d: got cyc=%0d x=%0d y=%0d found=%0d, required cyc=%0d x=%0d y=%0d found=%0d",
                   e.d, o.cyc, o.x, o.y, o.f, e.cyc, e.x, e.y, e.f);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL square_extra: got %0d extra obj_valid pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_below_min;
    res_t e, o;
    for (int y = 20; y <= 23; y++)
      for (int x = 10; x <= 13; x++)
        if (!(x == 13 && y == 23)) px(1'b1, 1'b1, x, y);
    expect_frame(11, 21, 1'b0, 11, 21, 1'b1);
    px(1'b1, 1'b0, 639, 479);
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL below_min dut%0d: got no obj_valid, required cyc=%0d x=%0d y=%0d found=%0d", e.d, e.cyc, e.x, e.y, e.f);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL below_min dut%0d: got cyc=%0d x=%0d y=%0d found=%0d, required cyc=%0d x=%0d y=%0d found=%0d",
                   e.d, o.cyc, o.x, o.y, o.f, e.cyc, e.x, e.y, e.f);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL below_min_extra: got %0d extra obj_valid pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_eof_counted;
    res_t e, o;
    px(1'b1, 1'b1, 0, 0);
    idle(2);
    expect_frame(11, 21, 1'b0, 319, 239, 1'b1);
    px(1'b1, 1'b1, 639, 479);
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL eof_counted dut%0d: got no obj_valid, required cyc=%0d x=%0d y=%0d found=%0d", e.d, e.cyc, e.x, e.y, e.f);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL eof_counted dut%0d: got cyc=%0d x=%0d y=%0d found=%0d, required cyc=%0d x=%0d y=%0d found=%0d",
                   e.d, o.cyc, o.x, o.y, o.f, e.cyc, e.x, e.y, e.f);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL eof_counted_extra: got %0d extra obj_valid pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    res_t e, o;
    for (int y = 50; y <= 53; y++)
      for (int x = 100; x <= 103; x++) px(1'b1, 1'b1, x, y);
    expect_frame(101, 51, 1'b1, 101, 51, 1'b1);
    px(1'b1, 1'b0, 639, 479);
    px(1'b1, 1'b1, 0, 0);
    px(1'b1, 1'b1, 2, 2);
    expect_frame(101, 51, 1'b0, 1, 1, 1'b1);
    px(1'b1, 1'b0, 639, 479);
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL back_to_back dut%0d: got no obj_valid, required cyc=%0d x=%0d y=%0d found=%0d", e.d, e.cyc, e.x, e.y, e.f);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL back_to_back dut%0d: got cyc=%0d x=%0d y=%0d found=%0d, required cyc=%0d x=%0d y=%0d found=%0d",
                   e.d, o.cyc, o.x, o.y, o.f, e.cyc, e.x, e.y, e.f);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL back_to_back_extra: got %0d extra obj_valid pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_ignored;
    res_t e, o;
    px(1'b0, 1'b1, 5, 5);
    px(1'b0, 1'b1, 639, 479);
    px(1'b1, 1'b1, 700, 5);
    px(1'b1, 1'b1, 5, 500);
    px(1'b1, 1'b1, 640, 479);
    idle(3);
    expect_frame(101, 51, 1'b0, 1, 1, 1'b0);
    px(1'b1, 1'b0, 639, 479);
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL ignored dut%0d: got no obj_valid, required cyc=%0d x=%0d y=%0d found=%0d", e.d, e.cyc, e.x, e.y, e.f);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL ignored dut%0d: got cyc=%0d x=%0d y=%0d found=%0d, required cyc=%0d x=%0d y=%0d found=%0d",
                   e.d, o.cyc, o.x, o.y, o.f, e.cyc, e.x, e.y, e.f);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL ignored_extra: got %0d extra obj_valid pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    res_t e, o;
    px(1'b1, 1'b1, 600, 400);
    px(1'b1, 1'b1, 601, 401);
    #2 areset = 1'b1;
    #1;
    tests_run++;
    if ({x_obj0, y_obj0, found0, valid0} !== 24'd0 || dut0.state_q !== ST_SEARCH) begin
      tests_failed++;
      $display("FAIL reset_mid dut0: got x=%0d y=%0d found=%0d valid=%0d state=%0d, required all 0 and SEARCH",
               x_obj0, y_obj0, found0, valid0, dut0.state_q);
    end
    tests_run++;
    if ({x_obj1, y_obj1, found1, valid1} !== 24'd0 || dut1.state_q !== ST_SEARCH) begin
      tests_failed++;
      $display("FAIL reset_mid dut1: got x=%0d y=%0d found=%0d valid=%0d state=%0d, required all 0 and SEARCH",
               x_obj1, y_obj1, found1, valid1, dut1.state_q);
    end
    @(posedge clk);
    #1 areset = 1'b0;
    px(1'b1, 1'b1, 30, 40);
    idle(3);
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_pulse: got %0d obj_valid pulses before end of frame, required 0", obs_q.size());
      obs_q.delete();
    end
    expect_frame(0, 0, 1'b0, 30, 40, 1'b1);
    px(1'b1, 1'b0, 639, 479);
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests_run++;
      if (obs_q.size() == 0) begin
        tests_failed++;
        $display("FAIL reset_mid_frame dut%0d: got no obj_valid, required cyc=%0d x=%0d y=%0d found=%0d", e.d, e.cyc, e.x, e.y, e.f);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL reset_mid_frame dut%0d: got cyc=%0d x=%0d y=%0d found=%0d, required cyc=%0d x=%0d y=%0d found=%0d",
                   e.d, o.cyc, o.x, o.y, o.f, e.cyc, e.x, e.y, e.f);
        end
      end
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_extra: got %0d extra obj_valid pulses, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_below_min();
    test_eof_counted();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_object_locate
`default_nettype wire

// File: doc/object_locate.md
# object_locate

Per-frame object locator feeding the red-box overlay stage. It consumes the streamed per-pixel object mask with VGA coordinates and tracks the bounding box of all mask hits in the frame. At the last active pixel it publishes the box centre as `x_obj`/`y_obj`, or holds the previous centre if too few pixels were seen. It sits between colour segmentation and the overlay logic, and produces the object centre the overlay consumes.

## Interface
- `DISP_WIDTH`, 11, width of pixel coordinates and of the centre outputs
- `H_ACTIVE`, 640, active pixels per line; last column is `H_ACTIVE-1`
- `V_ACTIVE`, 480, active lines per frame; last row is `V_ACTIVE-1`
- `MIN_PIXELS`, 16, minimum mask hits per frame for a valid detection
- `COUNT_WIDTH`, 20, width of the saturating hit counter
- `clk`  in  1  sole clock; all logic is on the rising edge
- `areset`  in  1  asynchronous, active-high reset
- `enable`  in  1  pixel qualifier; inputs are ignored when low
- `is_obj`  in  1  segmentation mask bit for the current pixel
- `x_pos`  in  DISP_WIDTH  current pixel column
- `y_pos`  in  DISP_WIDTH  current pixel row
- `x_obj`  out  DISP_WIDTH  registered object centre column; reset 0
- `y_obj`  out  DISP_WIDTH  registered object centre row; reset 0
- `found`  out  1  last completed frame met `MIN_PIXELS`; reset 0
- `obj_valid`  out  1  one-cycle pulse when the outputs are refreshed; reset 0

## Operation
- A pixel is "accepted" when `enable` is high, `x_pos < H_ACTIVE` and `y_pos < V_ACTIVE`. A hit is an accepted pixel with `is_obj` high.
- Per frame, the block accumulates `x_min`, `x_max`, `y_min`, `y_max` and `hits`.
  - `hits` saturates at 2^COUNT_WIDTH-1.
  - Min registers clear to all-ones; max registers clear to 0.
- End of frame is an accepted pixel at (`H_ACTIVE-1`, `V_ACTIVE-1`). That pixel counts toward the frame it closes.
- On the end-of-frame cycle:
  - Copy the accumulators, including that pixel's contribution, into snapshot registers.
  - Clear the accumulators, so the next accepted pixel starts the new frame with no stall.
- On the cycle after the end-of-frame cycle (UPDATE):
  - If snapshot `hits >= MIN_PIXELS`: set `x_obj = (x_min + x_max) >> 1` and `y_obj` likewise, computing the sum at DISP_WIDTH+1 bits. Set `found` = 1.
  - Otherwise: hold `x_obj`/`y_obj` and set `found` = 0.
  - In both cases, pulse `obj_valid`.
- FSM states:
  - SEARCH: no hit yet this frame. Moves to TRACK on a hit. On end of frame it moves to UPDATE, and hits = 0 gives `found` = 0.
  - TRACK: at least one hit this frame. Moves to UPDATE on end of frame.
  - UPDATE: lasts one cycle. Moves to TRACK if the pixel in this cycle is a hit, otherwise to SEARCH. That pixel is accumulated into the new frame.
- Pixels with `enable` low or out of range never change any state.
- Reset mid-frame clears the accumulators, the snapshot, the outputs and the FSM (to SEARCH). The next end of frame reports only hits seen after reset deassertion.

## Timing
- End-of-frame pixel presented in cycle T.
- Snapshot valid in T+1.
- `x_obj`, `y_obj`, `found` change at the T+1 → T+2 edge. `obj_valid` is high for exactly cycle T+2. Latency is 2 cycles.
- Outputs are stable between `obj_valid` pulses and are driven directly from flops.
- Accepted pixels can arrive every cycle, including at T+1 and T+2. There is no backpressure.
- `areset` takes effect immediately and asynchronously. Release is synchronous to `clk` by upstream convention.

## Structure
- Shared package `object_track_pkg`:
  - FSM state enum (SEARCH, TRACK, UPDATE)
  - Default `DISP_WIDTH`, `H_ACTIVE` and `V_ACTIVE` constants, shared with the overlay stage
- Sub-module `bbox_axis`: min/max tracker for one coordinate, with `clear`, `sample` and `coord` inputs and `min`/`max` outputs. It is instantiated once for x and once for y.
- The top level holds the FSM, the hit counter, the snapshot registers and the centre arithmetic.

## Test plan
- Assert `areset` mid-stream → all outputs read 0 and the FSM is in SEARCH. No `obj_valid` pulse appears until a full end of frame.
- 4x4 hit square at x 10..13, y 20..23, with defaults → one `obj_valid` pulse 2 cycles after pixel (639,479). `x_obj` = 11, `y_obj` = 21, `found` = 1.
- Next frame has 15 hits at the same place → `found` = 0 and `x_obj`/`y_obj` hold 11/21. `obj_valid` still pulses.
- `MIN_PIXELS` = 1, hits only at (0,0) and at the end-of-frame pixel (639,479) → `x_obj` = 319, `y_obj` = 239, `found` = 1. This proves the final pixel is counted.
- Frames back-to-back with no blanking: a hit at (0,0) of frame 2 arrives at T+1 and one at (2,2) at T+2 → frame 1's result is unaffected. Frame 2 (`MIN_PIXELS` = 1) reports centre (1,1).
- Hits presented with `enable` low, plus hits at x = 700 → ignored. Frame result is `found` = 0 and the centre is unchanged.
